// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, queue entry type and small helpers for the
// instruction fetch controller slice.
//   ADDR_W / DATA_W : ROM address / word widths
//   fetch_entry_t   : one prefetch queue entry {pc, instr}
//   rom_sel_e       : owner of the shared ROM port in a given cycle
//   pc_next()       : sequential PC increment, wraps modulo 2^ADDR_W
package fetch_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 16;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      ROM_SEL_FETCH = 1'b0,
      ROM_SEL_DATA  = 1'b1
   } rom_sel_e;

   function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(1);
   endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// instr_fetch_ctrl_if: bundles the ROM port, decode handshake, redirect,
// data-read port and occupancy of the fetch controller.
//   master : fetch controller side (drives rom_addr, instr*, drd_ack/data, q_count)
//   slave  : ROM / decode / requester side (drives everything else)
interface instr_fetch_ctrl_if #(
   parameter int unsigned DEPTH = 4
);
   import fetch_pkg::*;

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              fetch_en;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              instr_valid;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_ready;
   logic              drd_req;
   logic [ADDR_W-1:0] drd_addr;
   logic              drd_ack;
   logic [DATA_W-1:0] drd_data;
   logic [CNT_W-1:0]  q_count;

   modport master (
      output rom_addr,
      input  rom_data,
      input  fetch_en,
      input  redirect_valid,
      input  redirect_pc,
      output instr_valid,
      output instr,
      output instr_pc,
      input  instr_ready,
      input  drd_req,
      input  drd_addr,
      output drd_ack,
      output drd_data,
      output q_count
   );

   modport slave (
      input  rom_addr,
      output rom_data,
      output fetch_en,
      output redirect_valid,
      output redirect_pc,
      input  instr_valid,
      input  instr,
      input  instr_pc,
      output instr_ready,
      output drd_req,
      output drd_addr,
      input  drd_ack,
      input  drd_data,
      input  q_count
   );

endinterface

// File: rtl/instr_fetch_ctrl_fetch_queue.sv
// fetch_queue: circular prefetch buffer of fetch_entry_t.
//   clk, rst_n : clock, async active-low reset (clears storage, pointers, count)
//   flush      : drop all entries (pointers/count to 0, storage kept)
//   push/wdata : enqueue one entry (accepted when not full, or full with pop)
//   pop        : dequeue head entry (ignored when empty)
//   rdata      : head entry, combinational from storage
//   count      : occupancy 0..DEPTH; full/empty flags
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  fetch_entry_t             wdata,
   output fetch_entry_t             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // A push into a full queue is only legal when the head leaves in the same cycle.
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Power-of-two depth: pointers wrap by natural overflow.
         if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
         end
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch PC, shared ROM port arbitration and prefetch queue
// feeding decode; services data reads with priority over instruction fetch.
//   clk, rst_n : clock, async active-low reset
//   bus        : instr_fetch_ctrl_if.master
//                rom_addr/rom_data   combinational ROM port
//                fetch_en            enables prefetch (queue still drains when 0)
//                redirect_valid/pc   taken branch/jump; flushes the queue
//                instr_valid/ready   decode handshake; instr/instr_pc = head
//                drd_req/addr        data read; drd_ack/drd_data one cycle later
//                q_count             queue occupancy
module instr_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic             clk,
   input  logic             rst_n,
   instr_fetch_ctrl_if.master bus
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              drd_ack_q,  drd_ack_d;
   logic [DATA_W-1:0] drd_data_q, drd_data_d;

   rom_sel_e          rom_sel;
   logic              instr_valid;
   logic              push;
   logic              pop;
   fetch_entry_t      q_wdata;
   fetch_entry_t      q_rdata;
   logic [CNT_W-1:0]  q_count;
   logic              q_full;
   logic              q_empty;

   always_comb begin
      rom_sel = bus.drd_req ? ROM_SEL_DATA : ROM_SEL_FETCH;

      // Redirect hides the head so nothing stale is consumed in the flush cycle.
      instr_valid = !q_empty && !bus.redirect_valid;
      pop         = instr_valid && bus.instr_ready;
      push        = bus.fetch_en && !bus.drd_req && !bus.redirect_valid &&
                    (!q_full || pop);

      q_wdata.pc    = fetch_pc_q;
      q_wdata.instr = bus.rom_data;

      fetch_pc_d = fetch_pc_q;
      if (bus.redirect_valid) begin
         fetch_pc_d = bus.redirect_pc;
      end else if (push) begin
         fetch_pc_d = pc_next(fetch_pc_q);
      end

      // Data read owns the ROM port this cycle; redirect does not cancel it.
      drd_ack_d  = bus.drd_req;
      drd_data_d = bus.drd_req ? bus.rom_data : drd_data_q;
   end

   assign bus.rom_addr    = (rom_sel == ROM_SEL_DATA) ? bus.drd_addr : fetch_pc_q;
   assign bus.instr_valid = instr_valid;
   assign bus.instr       = q_rdata.instr;
   assign bus.instr_pc    = q_rdata.pc;
   assign bus.drd_ack     = drd_ack_q;
   assign bus.drd_data    = drd_data_q;
   assign bus.q_count     = q_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         drd_ack_q  <= 1'b0;
         drd_data_q <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         drd_ack_q  <= drd_ack_d;
         drd_data_q <= drd_data_d;
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (bus.redirect_valid),
      .push  (push),
      .pop   (pop),
      .wdata (q_wdata),
      .rdata (q_rdata),
      .count (q_count),
      .full  (q_full),
      .empty (q_empty)
   );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: scoreboard bench for instr_fetch_ctrl. The ROM is a
// function of the address; expected fetch streams and data-read results are
// queued when stimulus is driven and compared when decode accepts / drd_ack.
module tb_instr_fetch_ctrl;
   import fetch_pkg::*;

   localparam int unsigned       DEPTH    = 4;
   localparam logic [15:0]       RESET_PC = 16'h0000;

   logic clk;
   logic rst_n;

   instr_fetch_ctrl_if #(.DEPTH(DEPTH)) bus ();

   instr_fetch_ctrl #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] rom_word(input logic [15:0] a);
      return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'hA000);
   endfunction

   assign bus.rom_data = rom_word(bus.rom_addr);

   int unsigned   n_checks = 0;
   int unsigned   n_errors = 0;
   int unsigned   n_acc    = 0;
   fetch_entry_t  sb [$];
   logic [15:0]   dq [$];
   logic          ack_exp  = 1'b0;
   fetch_entry_t  e;
   logic [15:0]   d;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_stream(input logic [15:0] start, input int unsigned n);
      logic [15:0] pc;
      fetch_entry_t x;
      sb.delete();
      pc = start;
      for (int unsigned i = 0; i < n; i++) begin
         x.pc    = pc;
         x.instr = rom_word(pc);
         sb.push_back(x);
         pc = pc + 16'd1;
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         ack_exp = 1'b0;
      end else begin
         chk("drd_ack_timing", {31'd0, bus.drd_ack}, {31'd0, ack_exp});
         if (bus.drd_ack) begin
            if (dq.size() == 0) chk("drd_extra", 0, 1);
            else begin
               d = dq.pop_front();
               chk("drd_data", {16'd0, bus.drd_data}, {16'd0, d});
            end
         end
         ack_exp = bus.drd_req;
         if (bus.instr_valid && bus.instr_ready) begin
            n_acc++;
            if (sb.size() == 0) chk("sb_extra", 0, 1);
            else begin
               e = sb.pop_front();
               chk("instr_pc", {16'd0, bus.instr_pc}, {16'd0, e.pc});
               chk("instr", {16'd0, bus.instr}, {16'd0, e.instr});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n              = 1'b0;
      bus.fetch_en       = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.instr_ready    = 1'b0;
      bus.drd_req        = 1'b0;
      bus.drd_addr       = '0;
      #22;
      chk("rst_qcount", {29'd0, bus.q_count}, 0);
      chk("rst_valid", {31'd0, bus.instr_valid}, 0);
      chk("rst_ack", {31'd0, bus.drd_ack}, 0);
      chk("rst_drd_data", {16'd0, bus.drd_data}, 0);
      chk("rst_rom_addr", {16'd0, bus.rom_addr}, {16'd0, RESET_PC});

      // Reset release: valid appears on the second cycle.
      bus.fetch_en    = 1'b1;
      bus.instr_ready = 1'b1;
      expect_stream(RESET_PC, 64);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("lat_valid0", {31'd0, bus.instr_valid}, 0);
      @(negedge clk);
      chk("lat_valid1", {31'd0, bus.instr_valid}, 1);
      chk("lat_pc", {16'd0, bus.instr_pc}, {16'd0, RESET_PC});
      step();

      // Steady state: one instruction per cycle.
      begin
         int unsigned acc0;
         acc0 = n_acc;
         repeat (8) step();
         chk("throughput", n_acc - acc0, 8);
      end

      // Decode stalls: queue saturates, fetch PC freezes.
      bus.instr_ready = 1'b0;
      repeat (10) step();
      chk("full_qcount", {29'd0, bus.q_count}, DEPTH);
      chk("full_pc", {16'd0, bus.rom_addr}, (n_acc + DEPTH) & 32'hFFFF);
      chk("full_valid", {31'd0, bus.instr_valid}, 1);
      bus.instr_ready = 1'b1;
      repeat (6) step();

      // Drop one push to leave three entries, then redirect.
      bus.fetch_en = 1'b0;
      step();
      bus.fetch_en = 1'b1;
      chk("pre_redir_qcount", {29'd0, bus.q_count}, 3);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 16'h0040;
      expect_stream(16'h0040, 64);
      #1;
      chk("redir_valid0", {31'd0, bus.instr_valid}, 0);
      step();
      bus.redirect_valid = 1'b0;
      #1;
      chk("redir_valid1", {31'd0, bus.instr_valid}, 0);
      chk("redir_qcount", {29'd0, bus.q_count}, 0);
      step();
      chk("redir_valid2", {31'd0, bus.instr_valid}, 1);
      chk("redir_pc", {16'd0, bus.instr_pc}, 32'h0040);
      chk("redir_instr", {16'd0, bus.instr}, {16'd0, rom_word(16'h0040)});
      repeat (3) step();

      // Data reads steal the ROM port for one cycle each.
      bus.drd_req  = 1'b1;
      bus.drd_addr = 16'h1234;
      dq.push_back(rom_word(16'h1234));
      #1;
      chk("drd_rom_addr", {16'd0, bus.rom_addr}, 32'h1234);
      step();
      bus.drd_req = 1'b0;
      chk("drd_ack1", {31'd0, bus.drd_ack}, 1);
      chk("drd_beef", {16'd0, bus.drd_data}, 32'hBEEF);
      step();
      bus.drd_req  = 1'b1;
      bus.drd_addr = 16'h0005;
      dq.push_back(rom_word(16'h0005));
      step();
      bus.drd_addr = 16'h0006;
      dq.push_back(rom_word(16'h0006));
      step();
      bus.drd_req = 1'b0;
      chk("drd_b2b_data", {16'd0, bus.drd_data}, {16'd0, rom_word(16'h0006)});
      step();
      chk("drd_ack_drop", {31'd0, bus.drd_ack}, 0);
      chk("drd_hold", {16'd0, bus.drd_data}, {16'd0, rom_word(16'h0006)});
      repeat (4) step();

      // PC wrap across 16'hFFFF.
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 16'hFFFE;
      expect_stream(16'hFFFE, 64);
      step();
      bus.redirect_valid = 1'b0;
      repeat (8) step();

      // Asynchronous reset with three entries queued and an ack pending.
      bus.instr_ready = 1'b0;
      step();
      step();
      bus.fetch_en = 1'b0;
      bus.drd_req  = 1'b1;
      bus.drd_addr = 16'h0007;
      dq.push_back(rom_word(16'h0007));
      chk("mid_qcount", {29'd0, bus.q_count}, 3);
      step();
      bus.drd_req = 1'b0;
      chk("mid_ack", {31'd0, bus.drd_ack}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_qcount", {29'd0, bus.q_count}, 0);
      chk("arst_valid", {31'd0, bus.instr_valid}, 0);
      chk("arst_ack", {31'd0, bus.drd_ack}, 0);
      chk("arst_drd_data", {16'd0, bus.drd_data}, 0);
      dq.delete();
      expect_stream(RESET_PC, 64);
      bus.fetch_en    = 1'b1;
      bus.instr_ready = 1'b1;
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst2_valid0", {31'd0, bus.instr_valid}, 0);
      @(negedge clk);
      chk("rst2_valid1", {31'd0, bus.instr_valid}, 1);
      chk("rst2_pc", {16'd0, bus.instr_pc}, {16'd0, RESET_PC});
      step();
      repeat (6) step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Sequences the single-port combinational instruction ROM (16-bit address, 16-bit word, word-addressed) for the 16-bit RISC core.
- Holds the fetch PC and prefills a small prefetch queue that feeds decode through a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue.
- Shares the ROM port with a data-read requester (constant/table loads), which has priority over fetch.

Parameters:
- DEPTH, 4, prefetch queue entries; power of 2, >=2.
- RESET_PC, 16'h0000, fetch PC after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rom_addr  out  16  ROM address.
- rom_data  in  16  ROM word; combinational from rom_addr, same cycle.
- fetch_en  in  1  enables prefetch; 0 halts fetch, queue still drains.
- redirect_valid  in  1  PC redirect (taken branch/jump).
- redirect_pc  in  16  new fetch PC.
- instr_valid  out  1  queue head valid to decode.
- instr  out  16  head instruction word.
- instr_pc  out  16  address of head instruction.
- instr_ready  in  1  decode accepts head.
- drd_req  in  1  data-read request, single-cycle pulse per read.
- drd_addr  in  16  data-read address.
- drd_ack  out  1  one-cycle pulse: drd_data valid.
- drd_data  out  16  registered data-read result.
- q_count  out  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset, async on rst_n low:
  - fetch_pc=RESET_PC, count=0, rd/wr pointers=0, queue storage=0.
  - drd_ack=0, drd_data=0, hence instr_valid=0 and q_count=0.
- ROM port mux (combinational): rom_addr = drd_req ? drd_addr : fetch_pc.
- Data read:
  - When drd_req=1, rom_data is captured into drd_data at the edge and drd_ack=1 in the following cycle only.
  - Back-to-back requests give back-to-back acks.
  - drd_data holds its value until the next read.
- pop = instr_valid && instr_ready.
- instr_valid = (count!=0) && !redirect_valid. instr and instr_pc show the head entry combinationally.
- push = fetch_en && !drd_req && !redirect_valid && (count<DEPTH || pop).
  - On push: enqueue {fetch_pc, rom_data}; fetch_pc <= fetch_pc+1, wrapping modulo 2^16 (16'hFFFF -> 16'h0000).
- Redirect (redirect_valid=1):
  - count<=0 and pointers reset; fetch_pc<=redirect_pc.
  - No push and no pop that cycle.
  - A simultaneous drd_req is still serviced, since redirect touches registers only.
- Full queue (count==DEPTH): push only when pop occurs in the same cycle. Count is unchanged and the pointers advance.
- Empty queue: instr_valid=0; instr/instr_pc are don't-care but stable, showing the last head storage.
- Simultaneous push and pop at any count: count unchanged.
- Fetch stall: drd_req or fetch_en=0 blocks the push. fetch_pc is held and no entry is lost or duplicated.
- Latency:
  - From rst_n release, the first edge pushes ROM[RESET_PC], and instr_valid=1 from the next cycle.
  - After a redirect edge, the first edge pushes ROM[redirect_pc], and it is valid one cycle later.
  - Redirect-to-valid is therefore 2 cycles.
- Steady state: 1 instruction per cycle when decode is always ready and there is no data read.
- Reset asserted mid-operation: all state is cleared immediately and any pending drd_ack is dropped.

Decomposition:
- Package fetch_pkg:
  - ADDR_W=16, DATA_W=16.
  - typedef fetch_entry_t struct packed {logic [15:0] pc; logic [15:0] instr;}.
- Sub-module fetch_queue, a circular buffer of fetch_entry_t:
  - Ports: clk, rst_n, flush, push, pop, wdata, rdata, count, full, empty.
  - DEPTH parameter; same reset semantics as above.
- instr_fetch_ctrl holds the PC register, the ROM arbitration mux and the data-read response register.

Test Plan:
- Reset with ROM[0..7]=16'hA000+i, fetch_en=1, instr_ready=1 -> instr_valid rises 2nd cycle after rst_n release; instr sequence A000,A001,A002..., with instr_pc 0,1,2..., one per cycle.
- instr_ready=0 for 10 cycles -> q_count saturates at 4 and fetch_pc stops at 4. Raise ready -> A000..A003 then A004, with no gaps, duplicates or losses.
- Redirect to 16'h0040 while queue holds 3 entries -> instr_valid=0 in the redirect cycle and the next. Next accepted instr_pc=16'h0040 with ROM[0x40]; no stale entries appear.
- drd_req at addr 16'h1234 (ROM=16'hBEEF) during steady fetch -> rom_addr=16'h1234 that cycle; drd_ack=1 next cycle with drd_data=16'hBEEF. Fetch skips one push, and the instr_pc sequence stays contiguous.
- Redirect to 16'hFFFE -> instr_pc sequence FFFE, FFFF, 0000, 0001 (wrap).
- rst_n low while q_count=3 and a drd_req is outstanding -> q_count=0, instr_valid=0, drd_ack=0 immediately (asynchronously); restart fetches from RESET_PC.
